// File: rtl/meas_gate_ctrl.sv
// Measurement gate controller: times a window of whole input periods lasting at least
// GATE_CYCLES clocks and accumulates the edge, cycle and high-level counts over that window.
module meas_gate_ctrl #(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int GATE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             signal_in,
    input  logic             start,
    input  logic             auto_mode,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             timeout,
    output logic             ovf
);

    if (CLOCK_FREQ <= 0 || GATE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 2) begin : g_param_check
        $error("meas_gate_ctrl: invalid parameter set");
    end

    typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, DONE} state_t;

    localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
    localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [CNT_W-1:0] edge_acc_q, edge_acc_d;
    logic [CNT_W-1:0] total_acc_q, total_acc_d;
    logic [CNT_W-1:0] high_acc_q, high_acc_d;
    logic [31:0]      gate_tmr_q, gate_tmr_d;
    logic [31:0]      to_tmr_q, to_tmr_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic             to_flag_q, to_flag_d;
    logic             clear;

    logic [CNT_W-1:0] edge_cnt_q, total_cnt_q, high_cnt_q;
    logic             timeout_q, ovf_q, result_valid_q;

    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d     = state_q;
        edge_acc_d  = edge_acc_q;
        total_acc_d = total_acc_q;
        high_acc_d  = high_acc_q;
        gate_tmr_d  = gate_tmr_q;
        to_tmr_d    = to_tmr_q;
        ovf_acc_d   = ovf_acc_q;
        to_flag_d   = to_flag_q;
        clear       = 1'b0;

        // Window accumulation; each accumulator sticks at all-ones and flags overflow.
        if (state_q == GATE || state_q == CLOSE) begin
            if (&total_acc_q) ovf_acc_d = 1'b1;
            else              total_acc_d = total_acc_q + ONE;
            if (s2_q) begin
                if (&high_acc_q) ovf_acc_d = 1'b1;
                else             high_acc_d = high_acc_q + ONE;
            end
            if (rise) begin
                if (&edge_acc_q) ovf_acc_d = 1'b1;
                else             edge_acc_d = edge_acc_q + ONE;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = GATE;
                end else if (to_tmr_q == TO_LAST) begin
                    to_flag_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    to_tmr_d = to_tmr_q + 32'd1;
                end
            end
            GATE: begin
                if (gate_tmr_q == GATE_LAST) begin
                    state_d  = rise ? DONE : CLOSE;
                    to_tmr_d = '0;
                end else begin
                    gate_tmr_d = gate_tmr_q + 32'd1;
                end
            end
            CLOSE: begin
                if (rise) begin
                    state_d = DONE;
                end else if (to_tmr_q == TO_LAST) begin
                    to_flag_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    to_tmr_d = to_tmr_q + 32'd1;
                end
            end
            DONE: begin
                if (auto_mode) begin
                    clear   = 1'b1;
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            edge_acc_d  = '0;
            total_acc_d = '0;
            high_acc_d  = '0;
            gate_tmr_d  = '0;
            to_tmr_d    = '0;
            ovf_acc_d   = 1'b0;
            to_flag_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            edge_acc_q  <= '0;
            total_acc_q <= '0;
            high_acc_q  <= '0;
            gate_tmr_q  <= '0;
            to_tmr_q    <= '0;
            ovf_acc_q   <= 1'b0;
            to_flag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= signal_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            edge_acc_q  <= edge_acc_d;
            total_acc_q <= total_acc_d;
            high_acc_q  <= high_acc_d;
            gate_tmr_q  <= gate_tmr_d;
            to_tmr_q    <= to_tmr_d;
            ovf_acc_q   <= ovf_acc_d;
            to_flag_q   <= to_flag_d;
        end
    end

    // Results change only when leaving DONE, so they stay stable between measurements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q     <= '0;
            total_cnt_q    <= '0;
            high_cnt_q     <= '0;
            timeout_q      <= 1'b0;
            ovf_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                edge_cnt_q  <= to_flag_q ? '0 : edge_acc_q;
                total_cnt_q <= to_flag_q ? '0 : total_acc_q;
                high_cnt_q  <= to_flag_q ? '0 : high_acc_q;
                timeout_q   <= to_flag_q;
                ovf_q       <= ovf_acc_q;
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = result_valid_q;
    assign edge_cnt     = edge_cnt_q;
    assign total_cnt    = total_cnt_q;
    assign high_cnt     = high_cnt_q;
    assign timeout      = timeout_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_meas_gate_ctrl.sv
// Directed bench for meas_gate_ctrl with a short gate (1000 clk) and timeout (2000 clk).
module tb_meas_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        signal_in;
    logic        start;
    logic        auto_mode;
    logic        busy;
    logic        result_valid;
    logic [31:0] edge_cnt;
    logic [31:0] total_cnt;
    logic [31:0] high_cnt;
    logic        timeout;
    logic        ovf;

    int totalChecks = 0;
    int badChecks   = 0;
    int rvCount     = 0;
    int rvBase      = 0;
    int genPeriod   = 300;
    int genHigh     = 150;
    bit genEn       = 1'b0;
    int waitCycles;
    bit gotValid;

    meas_gate_ctrl #(
        .CLOCK_FREQ    (50000000),
        .GATE_CYCLES   (1000),
        .TIMEOUT_CYCLES(2000),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal_in   (signal_in),
        .start       (start),
        .auto_mode   (auto_mode),
        .busy        (busy),
        .result_valid(result_valid),
        .edge_cnt    (edge_cnt),
        .total_cnt   (total_cnt),
        .high_cnt    (high_cnt),
        .timeout     (timeout),
        .ovf         (ovf)
    );

    always #10 clk = ~clk;

    // Periodic test signal, updated shortly after each rising edge.
    initial begin
        int phase;
        phase     = 0;
        signal_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (genEn) begin
                if (phase >= genPeriod - 1) phase = 0;
                else                        phase = phase + 1;
                signal_in = (phase < genHigh);
            end else begin
                phase     = 0;
                signal_in = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (result_valid) rvCount = rvCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks = totalChecks + 1;
        assert (observed === expected)
        else begin
            badChecks = badChecks + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int period, input int highCycles, input bit enable);
        genPeriod = period;
        genHigh   = highCycles;
        genEn     = enable;
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitForValid(input int maxCycles, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < maxCycles && !seen) begin
            @(negedge clk);
            cycles = cycles + 1;
            if (result_valid) seen = 1'b1;
        end
    endtask

    task automatic checkResult(input string tag, input int expEdge, input int expTotal, input int expHigh, input bit expTo);
        checkOutput({tag, "_valid_seen"}, 32'(gotValid), 32'd1);
        checkOutput({tag, "_edge"},  edge_cnt,  expEdge);
        checkOutput({tag, "_total"}, total_cnt, expTotal);
        checkOutput({tag, "_high"},  high_cnt,  expHigh);
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'(expTo));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        auto_mode = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_edge", edge_cnt, 32'd0);
        checkOutput("rst_total", total_cnt, 32'd0);
        checkOutput("rst_high", high_cnt, 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // 300-cycle period, 50% duty: window = 4 periods from the arming rise.
        applyStimulus(300, 150, 1'b1);
        repeat (20) @(negedge clk);
        rvBase = rvCount;
        pulseStart();
        checkOutput("a_busy", 32'(busy), 32'd1);
        waitForValid(4000, waitCycles, gotValid);
        checkResult("a", 4, 1200, 600, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("a_once", 32'(rvCount - rvBase), 32'd1);
        checkOutput("a_idle", 32'(busy), 32'd0);
        checkOutput("a_hold_edge", edge_cnt, 32'd4);

        // 400-cycle period, 70% duty.
        applyStimulus(400, 280, 1'b1);
        repeat (20) @(negedge clk);
        pulseStart();
        waitForValid(4000, waitCycles, gotValid);
        checkResult("b", 3, 1200, 840, 1'b0);

        // No input activity: the arm timeout fires and counts read zero.
        applyStimulus(300, 150, 1'b0);
        repeat (20) @(negedge clk);
        pulseStart();
        waitForValid(3000, waitCycles, gotValid);
        checkResult("to", 0, 0, 0, 1'b1);
        checkOutput("to_latency", 32'(waitCycles >= 1999 && waitCycles <= 2002), 32'd1);

        // 250-cycle period: a rise lands on the final gate cycle, so no closing phase.
        applyStimulus(250, 125, 1'b1);
        repeat (20) @(negedge clk);
        pulseStart();
        waitForValid(4000, waitCycles, gotValid);
        checkResult("al", 4, 1000, 500, 1'b0);

        // Reset in the middle of the gate window.
        applyStimulus(300, 150, 1'b1);
        repeat (20) @(negedge clk);
        rvBase = rvCount;
        pulseStart();
        repeat (600) @(negedge clk);
        checkOutput("mr_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_edge", edge_cnt, 32'd0);
        checkOutput("mr_total", total_cnt, 32'd0);
        checkOutput("mr_high", high_cnt, 32'd0);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        checkOutput("mr_no_valid", 32'(rvCount - rvBase), 32'd0);
        checkOutput("mr_idle", 32'(busy), 32'd0);
        checkOutput("mr_total_after", total_cnt, 32'd0);

        // Auto mode: back-to-back identical results; start while busy is ignored.
        auto_mode = 1'b1;
        pulseStart();
        waitForValid(4000, waitCycles, gotValid);
        checkResult("au1", 4, 1200, 600, 1'b0);
        checkOutput("au1_rearmed", 32'(busy), 32'd1);
        repeat (200) @(negedge clk);
        pulseStart();
        waitForValid(4000, waitCycles, gotValid);
        checkResult("au2", 4, 1200, 600, 1'b0);
        auto_mode = 1'b0;
        waitForValid(4000, waitCycles, gotValid);
        checkResult("au3", 4, 1200, 600, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("au_stop_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
